// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU driver slice: command encoding,
// driver FSM states and the datapath width.
package alu_pkg;

    localparam int ALU_W = 32;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_XOR  = 3'd2,
        ALU_SLT  = 3'd3,
        ALU_AND  = 3'd4,
        ALU_NAND = 3'd5,
        ALU_NOR  = 3'd6,
        ALU_OR   = 3'd7
    } alu_cmd_t;

    typedef enum logic [1:0] {
        DRV_IDLE   = 2'd0,
        DRV_SETTLE = 2'd1,
        DRV_RESP   = 2'd2
    } alu_drv_state_t;

    // Only the arithmetic commands produce meaningful carry/zero/overflow.
    function automatic logic cmd_has_flags(alu_cmd_t cmd);
        return (cmd == ALU_ADD) || (cmd == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu_golden.sv
// Combinational behavioural reference for the 32-bit ALU, used by alu_driver
// to cross-check the gate-level ALU when ALU_DRIVER_CHECK_EN is defined.
module alu_golden
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] operand_a_i,
    input  logic [ALU_W-1:0] operand_b_i,
    input  logic [2:0]       command_i,
    output logic [ALU_W-1:0] result_o,
    output logic             carryout_o,
    output logic             zero_o,
    output logic             overflow_o
);

    alu_cmd_t       cmd;
    logic [ALU_W:0] sum;
    logic [ALU_W:0] diff;
    logic           lessThan;

    assign cmd      = alu_cmd_t'(command_i);
    assign sum      = {1'b0, operand_a_i} + {1'b0, operand_b_i};
    assign diff     = {1'b0, operand_a_i} + {1'b0, ~operand_b_i} + {{ALU_W{1'b0}}, 1'b1};
    assign lessThan = $signed(operand_a_i) < $signed(operand_b_i);

    // Overflow is the signed overflow of the two's-complement add/subtract.
    always_comb begin
        result_o   = '0;
        carryout_o = 1'b0;
        overflow_o = 1'b0;
        case (cmd)
            ALU_ADD: begin
                result_o   = sum[ALU_W-1:0];
                carryout_o = sum[ALU_W];
                overflow_o = (operand_a_i[ALU_W-1] == operand_b_i[ALU_W-1]) &&
                             (sum[ALU_W-1] != operand_a_i[ALU_W-1]);
            end
            ALU_SUB: begin
                result_o   = diff[ALU_W-1:0];
                carryout_o = diff[ALU_W];
                overflow_o = (operand_a_i[ALU_W-1] != operand_b_i[ALU_W-1]) &&
                             (diff[ALU_W-1] != operand_a_i[ALU_W-1]);
            end
            ALU_XOR:  result_o = operand_a_i ^ operand_b_i;
            ALU_SLT:  result_o = {{(ALU_W-1){1'b0}}, lessThan};
            ALU_AND:  result_o = operand_a_i & operand_b_i;
            ALU_NAND: result_o = ~(operand_a_i & operand_b_i);
            ALU_NOR:  result_o = ~(operand_a_i | operand_b_i);
            ALU_OR:   result_o = operand_a_i | operand_b_i;
            default:  result_o = '0;
        endcase
    end

    assign zero_o = cmd_has_flags(cmd) && (result_o == '0);

endmodule

// File: rtl/alu_driver.sv
// Sequential valid/ready front end for the combinational ALU: latch, settle,
// capture, respond. Define ALU_DRIVER_CHECK_EN to enable the golden-model check.
module alu_driver
    import alu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [ALU_W-1:0] req_a,
    input  logic [ALU_W-1:0] req_b,
    input  logic [2:0]       req_cmd,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [ALU_W-1:0] rsp_result,
    output logic             rsp_carryout,
    output logic             rsp_zero,
    output logic             rsp_overflow,
    output logic             rsp_mismatch,
    output logic [15:0]      err_count,
    output logic [ALU_W-1:0] alu_operandA,
    output logic [ALU_W-1:0] alu_operandB,
    output logic [2:0]       alu_command,
    input  logic [ALU_W-1:0] alu_result,
    input  logic             alu_carryout,
    input  logic             alu_zero,
    input  logic             alu_overflow
);

    // Legal SETTLE_CYCLES range is 1..255, so the load value always fits 8 bits.
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    alu_drv_state_t   state_q;
    logic [7:0]       count_q;
    logic             reqReady_q;
    logic [ALU_W-1:0] aluOperandA_q;
    logic [ALU_W-1:0] aluOperandB_q;
    logic [2:0]       aluCommand_q;
    logic             rspValid_q;
    logic [ALU_W-1:0] rspResult_q;
    logic             rspCarry_q;
    logic             rspZero_q;
    logic             rspOverflow_q;
    logic             rspMismatch_q;
    logic [15:0]      errCount_q;

    logic             mismatch_d;
    logic [15:0]      errCount_d;

`ifdef ALU_DRIVER_CHECK_EN
    logic [ALU_W-1:0] goldResult;
    logic             goldCarry;
    logic             goldZero;
    logic             goldOverflow;

    alu_golden u_golden (
        .operand_a_i (aluOperandA_q),
        .operand_b_i (aluOperandB_q),
        .command_i   (aluCommand_q),
        .result_o    (goldResult),
        .carryout_o  (goldCarry),
        .zero_o      (goldZero),
        .overflow_o  (goldOverflow)
    );

    assign mismatch_d = (goldResult   != alu_result)   ||
                        (goldCarry    != alu_carryout) ||
                        (goldZero     != alu_zero)     ||
                        (goldOverflow != alu_overflow);
    assign errCount_d = (mismatch_d && (errCount_q != 16'hFFFF)) ? errCount_q + 16'd1
                                                                 : errCount_q;
`else
    assign mismatch_d = 1'b0;
    assign errCount_d = 16'd0;
`endif

    // The alu_* registers only load on acceptance so the ripple path never
    // sees spurious transitions while settling or while the response waits.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= DRV_IDLE;
            count_q       <= 8'd0;
            reqReady_q    <= 1'b1;
            aluOperandA_q <= '0;
            aluOperandB_q <= '0;
            aluCommand_q  <= 3'd0;
            rspValid_q    <= 1'b0;
            rspResult_q   <= '0;
            rspCarry_q    <= 1'b0;
            rspZero_q     <= 1'b0;
            rspOverflow_q <= 1'b0;
            rspMismatch_q <= 1'b0;
            errCount_q    <= 16'd0;
        end else begin
            case (state_q)
                DRV_IDLE: begin
                    if (req_valid) begin
                        aluOperandA_q <= req_a;
                        aluOperandB_q <= req_b;
                        aluCommand_q  <= req_cmd;
                        count_q       <= SETTLE_LOAD;
                        reqReady_q    <= 1'b0;
                        state_q       <= DRV_SETTLE;
                    end
                end
                DRV_SETTLE: begin
                    if (count_q != 8'd0) begin
                        count_q <= count_q - 8'd1;
                    end else begin
                        rspResult_q   <= alu_result;
                        rspCarry_q    <= alu_carryout;
                        rspZero_q     <= alu_zero;
                        rspOverflow_q <= alu_overflow;
                        rspMismatch_q <= mismatch_d;
                        errCount_q    <= errCount_d;
                        rspValid_q    <= 1'b1;
                        state_q       <= DRV_RESP;
                    end
                end
                DRV_RESP: begin
                    if (rsp_ready) begin
                        rspValid_q    <= 1'b0;
                        rspMismatch_q <= 1'b0;
                        reqReady_q    <= 1'b1;
                        state_q       <= DRV_IDLE;
                    end
                end
                default: begin
                    state_q    <= DRV_IDLE;
                    reqReady_q <= 1'b1;
                    rspValid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready    = reqReady_q;
    assign rsp_valid    = rspValid_q;
    assign rsp_result   = rspResult_q;
    assign rsp_carryout = rspCarry_q;
    assign rsp_zero     = rspZero_q;
    assign rsp_overflow = rspOverflow_q;
    assign rsp_mismatch = rspMismatch_q;
    assign err_count    = errCount_q;
    assign alu_operandA = aluOperandA_q;
    assign alu_operandB = aluOperandB_q;
    assign alu_command  = aluCommand_q;

endmodule

// File: tb/tb_alu_driver.sv
// Scoreboard bench for alu_driver: directed vectors with hand-computed results,
// a behavioural ALU stand-in with fault injection, and a decoupled response monitor.
module tb_alu_driver;
    import alu_pkg::*;

    localparam int SETTLE = 4;
`ifdef ALU_DRIVER_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic [31:0] req_a, req_b;
    logic [2:0]  req_cmd;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_carryout, rsp_zero, rsp_overflow, rsp_mismatch;
    logic [15:0] err_count;
    logic [31:0] alu_operandA, alu_operandB, alu_result;
    logic [2:0]  alu_command;
    logic        alu_carryout, alu_zero, alu_overflow;
    logic        corrupt = 1'b0;

    always #5 clk = ~clk;

    alu_driver #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_cmd      (req_cmd),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_carryout (rsp_carryout),
        .rsp_zero     (rsp_zero),
        .rsp_overflow (rsp_overflow),
        .rsp_mismatch (rsp_mismatch),
        .err_count    (err_count),
        .alu_operandA (alu_operandA),
        .alu_operandB (alu_operandB),
        .alu_command  (alu_command),
        .alu_result   (alu_result),
        .alu_carryout (alu_carryout),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow)
    );

    // Stand-in for the gate-level ALU; 'corrupt' flips result bit 0 on ADD.
    always_comb begin
        logic [32:0] s;
        s            = '0;
        alu_result   = '0;
        alu_carryout = 1'b0;
        alu_zero     = 1'b0;
        alu_overflow = 1'b0;
        case (alu_command)
            3'd0: begin
                s            = {1'b0, alu_operandA} + {1'b0, alu_operandB};
                alu_result   = s[31:0];
                alu_carryout = s[32];
                alu_overflow = (alu_operandA[31] == alu_operandB[31]) && (s[31] != alu_operandA[31]);
                alu_zero     = (s[31:0] == 32'd0);
            end
            3'd1: begin
                s            = {1'b0, alu_operandA} + {1'b0, ~alu_operandB} + 33'd1;
                alu_result   = s[31:0];
                alu_carryout = s[32];
                alu_overflow = (alu_operandA[31] != alu_operandB[31]) && (s[31] != alu_operandA[31]);
                alu_zero     = (s[31:0] == 32'd0);
            end
            3'd2: alu_result = alu_operandA ^ alu_operandB;
            3'd3: alu_result = {31'd0, $signed(alu_operandA) < $signed(alu_operandB)};
            3'd4: alu_result = alu_operandA & alu_operandB;
            3'd5: alu_result = ~(alu_operandA & alu_operandB);
            3'd6: alu_result = ~(alu_operandA | alu_operandB);
            default: alu_result = alu_operandA | alu_operandB;
        endcase
        if (corrupt && alu_command == 3'd0) alu_result[0] = ~alu_result[0];
    end

    typedef struct {
        logic [31:0] a, b;
        logic [2:0]  cmd;
        logic [31:0] res;
        logic        c, z, o, mm;
        logic [15:0] ec;
    } vec_t;

    typedef struct {
        vec_t v;
        int   acceptEdge;
    } sb_t;

    sb_t  sbQ[$];
    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;
    int   cycle  = 0;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic vec_t mk(input logic [31:0] a, b, input logic [2:0] cmd,
                                input logic [31:0] res, input logic c, z, o, mm,
                                input logic [15:0] ec);
        vec_t v;
        v.a = a; v.b = b; v.cmd = cmd; v.res = res;
        v.c = c; v.z = z; v.o = o; v.mm = mm; v.ec = ec;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops on the first cycle of each response, then checks hold-stability.
    logic        inRsp = 1'b0;
    logic [31:0] snapRes;
    logic        snapC, snapZ, snapO;

    always @(negedge clk) begin
        sb_t e;
        if (reset || !rsp_valid) begin
            inRsp = 1'b0;
        end else if (!inRsp) begin
            inRsp = 1'b1;
            if (sbQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedRsp: got rsp_valid=1 expected no response");
            end else begin
                e = sbQ.pop_front();
                checkOutput("latency",  cycle, e.acceptEdge + SETTLE);
                checkOutput("result",   rsp_result, e.v.res);
                checkOutput("carryout", {31'd0, rsp_carryout}, {31'd0, e.v.c});
                checkOutput("zero",     {31'd0, rsp_zero}, {31'd0, e.v.z});
                checkOutput("overflow", {31'd0, rsp_overflow}, {31'd0, e.v.o});
                checkOutput("mismatch", {31'd0, rsp_mismatch}, {31'd0, e.v.mm});
                checkOutput("errCount", {16'd0, err_count}, {16'd0, e.v.ec});
            end
            snapRes = rsp_result;
            snapC   = rsp_carryout;
            snapZ   = rsp_zero;
            snapO   = rsp_overflow;
        end else begin
            checkOutput("holdResult", rsp_result, snapRes);
            checkOutput("holdFlags", {29'd0, rsp_carryout, rsp_zero, rsp_overflow},
                        {29'd0, snapC, snapZ, snapO});
        end
    end

    task automatic applyStimulus(input vec_t v, input bit expectRsp);
        int  guard = 0;
        sb_t e;
        @(negedge clk);
        req_a     = v.a;
        req_b     = v.b;
        req_cmd   = v.cmd;
        req_valid = 1'b1;
        while (!req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL acceptTimeout: got req_ready=0 expected 1 within 200 cycles");
        end else if (expectRsp) begin
            e.v          = v;
            e.acceptEdge = cycle + 1;
            sbQ.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_a     = 32'hDEAD_BEEF;
        req_b     = 32'hCAFE_F00D;
        req_cmd   = 3'd7;
    endtask

    task automatic waitDrain();
        int guard = 0;
        while ((sbQ.size() != 0 || rsp_valid) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        if (sbQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drainTimeout: got %0d pending expected 0", sbQ.size());
            sbQ.delete();
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vA, vB, vC;
        int   guard;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_cmd   = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        checkOutput("rstReqReady", {31'd0, req_ready}, 32'd1);
        checkOutput("rstRspValid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("rstResult",   rsp_result, 32'd0);
        checkOutput("rstFlags",    {28'd0, rsp_carryout, rsp_zero, rsp_overflow, rsp_mismatch}, 32'd0);
        checkOutput("rstErrCount", {16'd0, err_count}, 32'd0);
        checkOutput("rstOperandA", alu_operandA, 32'd0);
        checkOutput("rstOperandB", alu_operandB, 32'd0);
        checkOutput("rstCommand",  {29'd0, alu_command}, 32'd0);

        vecs.push_back(mk(32'h7FFF_FFFF, 32'h0000_0001, 3'd0, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0));
        vecs.push_back(mk(32'h0000_0005, 32'h0000_0005, 3'd1, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0));
        vecs.push_back(mk(32'hFFFF_FFFF, 32'h0000_0001, 3'd3, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
        vecs.push_back(mk(32'hF0F0_F0F0, 32'hFFFF_0000, 3'd2, 32'h0F0F_F0F0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
        vecs.push_back(mk(32'hFF00_FF00, 32'h0F0F_0F0F, 3'd4, 32'h0F00_0F00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
        vecs.push_back(mk(32'hFF00_FF00, 32'h0F0F_0F0F, 3'd5, 32'hF0FF_F0FF, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
        vecs.push_back(mk(32'hFF00_FF00, 32'h0F0F_0F0F, 3'd6, 32'h00F0_00F0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
        vecs.push_back(mk(32'hFF00_FF00, 32'h0F0F_0F0F, 3'd7, 32'hFF0F_FF0F, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
        vecs.push_back(mk(32'hFFFF_FFFF, 32'h0000_0001, 3'd0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0));
        vecs.push_back(mk(32'h8000_0000, 32'h0000_0001, 3'd1, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0));
        vecs.push_back(mk(32'h0000_0001, 32'hFFFF_FFFF, 3'd3, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));

        foreach (vecs[i]) applyStimulus(vecs[i], 1'b1);
        waitDrain();

        // Backpressure: response held 10 cycles while the next request waits.
        vA = mk(32'h1234_5678, 32'h1111_1111, 3'd0, 32'h2345_6789, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        vB = mk(32'hA5A5_0000, 32'h0000_5A5A, 3'd7, 32'hA5A5_5A5A, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        rsp_ready = 1'b0;
        applyStimulus(vA, 1'b1);
        guard = 0;
        while (!rsp_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("bpRspValid", {31'd0, rsp_valid}, 32'd1);
        req_a     = vB.a;
        req_b     = vB.b;
        req_cmd   = vB.cmd;
        req_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            checkOutput("bpReqReady", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("bpAcceptAfterHs", {31'd0, req_ready}, 32'd1);
        if (req_ready) begin
            sb_t e;
            e.v          = vB;
            e.acceptEdge = cycle + 1;
            sbQ.push_back(e);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        waitDrain();

        // Faulty ALU on ADD 1+1, then a clean operation.
        corrupt = 1'b1;
        applyStimulus(mk(32'd1, 32'd1, 3'd0, 32'd3, 1'b0, 1'b0, 1'b0, CHK, CHK ? 16'd1 : 16'd0), 1'b1);
        waitDrain();
        corrupt = 1'b0;
        applyStimulus(mk(32'd2, 32'd3, 3'd0, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0, CHK ? 16'd1 : 16'd0), 1'b1);
        waitDrain();

        // Reset while settling abandons the operation.
        vC = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd4, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        applyStimulus(vC, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midRstRspValid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("midRstOperandA", alu_operandA, 32'd0);
        checkOutput("midRstOperandB", alu_operandB, 32'd0);
        checkOutput("midRstCommand",  {29'd0, alu_command}, 32'd0);
        checkOutput("midRstResult",   rsp_result, 32'd0);
        checkOutput("midRstErrCount", {16'd0, err_count}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("midRstReqReady", {31'd0, req_ready}, 32'd1);
        for (int k = 0; k < 8; k++) begin
            checkOutput("midRstNoRsp", {31'd0, rsp_valid}, 32'd0);
            @(negedge clk);
        end

        applyStimulus(mk(32'd3, 32'd5, 3'd1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0), 1'b1);
        waitDrain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_driver.md
# alu_driver

Sequential front end for the 32-bit combinational ALU. It accepts one operation at a time over a valid/ready request channel, drives the ALU operand and command inputs from registers, and waits a fixed settle interval for the gate-level ripple path to resolve. It then captures the result and flags and returns them over a valid/ready response channel. It sits between the datapath controller and the ALU.

## Interface
- SETTLE_CYCLES, default 4: cycles the ALU inputs are held before capture; legal range 1..255.
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  driver can accept a request
- req_a  in  32  operand A
- req_b  in  32  operand B
- req_cmd  in  3  command
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  32  captured result
- rsp_carryout, rsp_zero, rsp_overflow  out  1 each  captured flags
- rsp_mismatch  out  1  golden-model disagreement; see Configuration
- err_count  out  16  mismatch count; see Configuration
- alu_operandA, alu_operandB  out  32 each  registered drive to ALU
- alu_command  out  3  registered drive to ALU
- alu_result  in  32, alu_carryout / alu_zero / alu_overflow  in  1 each  raw ALU outputs

## Operation
- Command encoding:
  - 0 ADD, 1 SUB, 2 XOR, 3 SLT (signed), 4 AND, 5 NAND, 6 NOR, 7 OR.
  - Flags are meaningful only for ADD/SUB; the ALU returns them as 0 otherwise, and the driver passes them through unmodified.
- FSM states: IDLE, SETTLE, RESP.
  - IDLE: req_ready=1. On req_valid, latch req_a/req_b/req_cmd into the alu_* registers, load the counter with SETTLE_CYCLES-1, and go to SETTLE.
  - SETTLE: req_ready=0. While count≠0, decrement. At count=0, capture the alu_* inputs into the rsp_* registers and go to RESP.
  - RESP: rsp_valid=1. The rsp_* outputs are stable until the handshake. On rsp_valid&&rsp_ready, go to IDLE.
- The alu_* registers change only on request acceptance. They hold the last operation afterwards, so the ALU never sees spurious transitions.
- No request is accepted in SETTLE or RESP. There is no same-cycle response-to-request overlap.
- Counter width is 8 bits and it never wraps. SETTLE_CYCLES=1 means capture on the edge immediately after acceptance.

## Timing
- Reset state: IDLE. All registered outputs are 0, including alu_*, rsp_*, rsp_valid, rsp_mismatch and err_count. req_ready=1 in the first cycle after reset is released.
- Latency: an accept on edge E0 makes rsp_valid high after edge E0+SETTLE_CYCLES.
- Minimum throughput: one operation per SETTLE_CYCLES+2 cycles. req_ready rises in the cycle after the response handshake.
- Reset mid-operation (SETTLE or RESP): the operation is abandoned, no response is issued, and all outputs return to reset values on that edge.
- req_valid may drop before acceptance without effect. Request data is sampled only on the accepting edge.

## Configuration
- Macro ALU_DRIVER_CHECK_EN.
- Defined:
  - A behavioural golden model computes the expected result and flags from the latched operands.
  - ADD/SUB carry is bit 32 of A+B or A+~B+1. Overflow is the signed overflow. Zero is result==0 for ADD/SUB only. All flags are 0 for other commands.
  - SLT gives 1 when $signed(A)<$signed(B), else 0.
  - At capture, rsp_mismatch is set to (expected≠captured) over the result and all three flags. It is held through RESP and cleared on leaving RESP.
  - err_count increments on each mismatch and saturates at 0xFFFF.
- Undefined: the golden model is absent, and rsp_mismatch and err_count are tied to 0. The ports remain present.

## Structure
- Package alu_pkg holds:
  - command constants ALU_ADD..ALU_OR (3-bit typedef alu_cmd_t);
  - the state enum alu_drv_state_t;
  - the width constant ALU_W=32.
- Sub-module alu_golden: a combinational reference model, instantiated only under ALU_DRIVER_CHECK_EN.

## Test plan
- Reset held 3 cycles, then released -> all outputs 0, req_ready=1, rsp_valid=0.
- ADD 0x7FFFFFFF+0x00000001, SETTLE_CYCLES=4 -> rsp_valid exactly 4 edges after accept; result 0x80000000, overflow=1, carryout=0, zero=0.
- SUB 0x00000005−0x00000005 -> result 0, zero=1, carryout=1, overflow=0.
- SLT A=0xFFFFFFFF, B=0x00000001 -> result 0x00000001, all flags 0; XOR 0xF0F0F0F0^0xFFFF0000 -> result 0x0F0FF0F0.
- Backpressure and reset:
  - rsp_ready low for 10 cycles while the next req_valid is held -> rsp_* stable and req_ready=0 throughout; the next request is accepted in the cycle after the handshake.
  - Reset asserted during SETTLE -> no rsp_valid, outputs reset.
- With ALU_DRIVER_CHECK_EN and an ALU stub forcing result bit 0 wrong on ADD 1+1 -> rsp_mismatch=1 and err_count=1. A correct op follows -> rsp_mismatch=0 and err_count stays 1.
